// File: rtl/controlador_entrada_switch_pkg.sv
// controlador_entrada_switch_pkg: shared types, widths and sign extension for the IN path
package controlador_entrada_switch_pkg;
  localparam int LARGURA_DADO = 32;
  localparam int LARGURA_SWITCH = 9;
  typedef enum logic [1:0] {OCIOSO, ESPERA_LIVRE, ESPERA_PRESSIONA, ENTREGA} estado_t;
  function automatic logic [LARGURA_DADO-1:0] estendeSinal(input logic [LARGURA_SWITCH-1:0] valor);
    return {{(LARGURA_DADO-LARGURA_SWITCH){valor[LARGURA_SWITCH-1]}}, valor};
  endfunction
endpackage

// File: rtl/controlador_entrada_switch_if.sv
// controlador_entrada_switch_if: request/data bundle between the control unit and the input stage
interface controlador_entrada_switch_if;
  import controlador_entrada_switch_pkg::*;
  logic [LARGURA_SWITCH-1:0] entradaSwitch;
  logic pedidoEntrada;
  logic aguardando;
  logic [LARGURA_DADO-1:0] dado;
  logic dadoValido;
  logic [7:0] contagemEntradas;
  modport slave(input entradaSwitch, pedidoEntrada, output aguardando, dado, dadoValido, contagemEntradas);
  modport master(output entradaSwitch, pedidoEntrada, input aguardando, dado, dadoValido, contagemEntradas);
endinterface

// File: rtl/controlador_entrada_switch_filtro_debounce.sv
// filtro_debounce: synchronises the raw button, normalises it to 1 = pressed and filters bounce
module filtro_debounce #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int ENTER_ATIVO_BAIXO = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic nivel,
  output logic evPressiona
);
  localparam int LARGURA_CONTADOR = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic SOLTO = (ENTER_ATIVO_BAIXO != 0);
  localparam logic [LARGURA_CONTADOR-1:0] LIMITE = LARGURA_CONTADOR'(DEBOUNCE_CICLOS - 1);
  logic [1:0] sincronizador;
  logic [LARGURA_CONTADOR-1:0] contador;
  logic pressionadoSinc;
  assign pressionadoSinc = sincronizador[1] ^ SOLTO;
  // two-flop synchroniser, then a run of DEBOUNCE_CICLOS differing samples flips the accepted level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sincronizador <= {2{SOLTO}};
      contador <= '0;
      nivel <= 1'b0;
      evPressiona <= 1'b0;
    end else begin
      sincronizador <= {sincronizador[0], enter};
      evPressiona <= 1'b0;
      if (pressionadoSinc == nivel) contador <= '0;
      else if (contador == LIMITE) begin
        nivel <= ~nivel;
        contador <= '0;
        evPressiona <= ~nivel;
      end else contador <= contador + 1'b1;
    end
  end
endmodule

// File: rtl/controlador_entrada_switch.sv
// controlador_entrada_switch: stalls the CPU on an IN request until one clean press, then delivers the switches
module controlador_entrada_switch
  import controlador_entrada_switch_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int ENTER_ATIVO_BAIXO = 1
) (
  input logic clock,
  input logic reset,
  input logic enter,
  controlador_entrada_switch_if.slave barramento
);
  estado_t estado, proxEstado;
  logic nivel, evPressiona, aguardandoReg, dadoValidoReg, captura;
  logic [LARGURA_DADO-1:0] dadoReg;
  logic [7:0] contagemReg;
  filtro_debounce #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS), .ENTER_ATIVO_BAIXO(ENTER_ATIVO_BAIXO)) uFiltro (
    .clock(clock),
    .reset(reset),
    .enter(enter),
    .nivel(nivel),
    .evPressiona(evPressiona)
  );
  assign captura = estado == ESPERA_PRESSIONA && barramento.pedidoEntrada && evPressiona;
  assign barramento.aguardando = aguardandoReg;
  assign barramento.dadoValido = dadoValidoReg;
  assign barramento.dado = dadoReg;
  assign barramento.contagemEntradas = contagemReg;
  // next state; a dropped request aborts any wait, and a button still held from a previous IN must be released first
  always_comb begin
    proxEstado = OCIOSO;
    case (estado)
      OCIOSO: proxEstado = !barramento.pedidoEntrada ? OCIOSO : nivel ? ESPERA_LIVRE : ESPERA_PRESSIONA;
      ESPERA_LIVRE: proxEstado = !barramento.pedidoEntrada ? OCIOSO : nivel ? ESPERA_LIVRE : ESPERA_PRESSIONA;
      ESPERA_PRESSIONA: proxEstado = !barramento.pedidoEntrada ? OCIOSO : evPressiona ? ENTREGA : ESPERA_PRESSIONA;
      ENTREGA: proxEstado = OCIOSO;
    endcase
  end
  // state plus registered Moore outputs, and the capture of the sign-extended switches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      aguardandoReg <= 1'b0;
      dadoValidoReg <= 1'b0;
      dadoReg <= '0;
      contagemReg <= '0;
    end else begin
      estado <= proxEstado;
      aguardandoReg <= proxEstado == ESPERA_LIVRE || proxEstado == ESPERA_PRESSIONA;
      dadoValidoReg <= proxEstado == ENTREGA;
      if (captura) begin
        dadoReg <= estendeSinal(barramento.entradaSwitch);
        contagemReg <= contagemReg + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_controlador_entrada_switch.sv
// tb_controlador_entrada_switch: table, directed and random checks against a behavioural model
module tb_controlador_entrada_switch;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enter = 1'b1;
  controlador_entrada_switch_if barramento();
  controlador_entrada_switch #(.DEBOUNCE_CICLOS(D), .ENTER_ATIVO_BAIXO(1)) dut (
    .clock(clock),
    .reset(reset),
    .enter(enter),
    .barramento(barramento)
  );
  always #5 clock = ~clock;

  typedef struct {
    logic [8:0] sw;
    logic [31:0] dadoEsperado;
  } vetor_t;
  vetor_t tabela[7];

  int comparados = 0;
  int divergentes = 0;
  int strobes = 0;

  // model: last two raw samples, history of synchronised samples, accepted level and request phase
  bit [1:0] mLinha;
  bit mHist[$];
  bit mDeb, mEv, mLivre, mPress, mEntrega;
  logic [31:0] mDado;
  logic [7:0] mCont;

  task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    comparados++;
    if (atual !== esperado) begin
      divergentes++;
      $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic modeloReset();
    mLinha = 2'b00;
    mHist.delete();
    mDeb = 0; mEv = 0; mLivre = 0; mPress = 0; mEntrega = 0;
    mDado = 32'd0; mCont = 8'd0;
  endtask

  task automatic modeloPasso(input logic e, input logic [8:0] sw, input logic p);
    bit x, debAnt, evAnt, todos;
    int v;
    debAnt = mDeb; evAnt = mEv; x = mLinha[1];
    mLinha = {mLinha[0], ~e};
    mHist.push_back(x);
    if (mHist.size() > D) void'(mHist.pop_front());
    todos = (mHist.size() == D);
    foreach (mHist[i]) if (mHist[i] == debAnt) todos = 0;
    mEv = todos && !debAnt;
    if (todos) mDeb = ~debAnt;
    if (mEntrega) mEntrega = 0;
    else if (mLivre) begin
      if (!p) mLivre = 0;
      else if (!debAnt) begin mLivre = 0; mPress = 1; end
    end else if (mPress) begin
      if (!p) mPress = 0;
      else if (evAnt) begin
        mPress = 0; mEntrega = 1;
        v = sw[8] ? int'(sw) - 512 : int'(sw);
        mDado = 32'(v);
        mCont = mCont + 8'd1;
      end
    end else if (p) begin
      if (debAnt) mLivre = 1; else mPress = 1;
    end
  endtask

  task automatic comparaTudo();
    confere("aguardando", 32'(barramento.aguardando), 32'(mLivre | mPress));
    confere("dadoValido", 32'(barramento.dadoValido), 32'(mEntrega));
    confere("dado", barramento.dado, mDado);
    confere("contagemEntradas", 32'(barramento.contagemEntradas), 32'(mCont));
  endtask

  task automatic passo(input logic e, input logic [8:0] sw, input logic p);
    enter = e;
    barramento.entradaSwitch = sw;
    barramento.pedidoEntrada = p;
    @(posedge clock);
    if (!reset) modeloReset(); else modeloPasso(e, sw, p);
    #1;
    if (barramento.dadoValido) strobes++;
    comparaTudo();
    @(negedge clock);
  endtask

  task automatic aplicaReset();
    reset = 1'b0;
    #1;
    modeloReset();
    comparaTudo();
  endtask

  task automatic captura(input logic [8:0] sw, output int novos);
    int s0;
    s0 = strobes;
    repeat (7) passo(1'b1, sw, 1'b0);
    for (int i = 0; i < 30 && strobes == s0; i++) passo(1'b0, sw, 1'b1);
    novos = strobes - s0;
    passo(1'b0, sw, 1'b0);
  endtask

  initial begin
    int n, s0, novos;
    logic [31:0] dadoSalvo;
    logic [7:0] contSalva;
    logic e, p;
    int len;
    tabela[0] = '{9'h0FF, 32'h000000FF};
    tabela[1] = '{9'h100, 32'hFFFFFF00};
    tabela[2] = '{9'h1FF, 32'hFFFFFFFF};
    tabela[3] = '{9'h000, 32'h00000000};
    tabela[4] = '{9'h001, 32'h00000001};
    tabela[5] = '{9'h0AA, 32'h000000AA};
    tabela[6] = '{9'h155, 32'hFFFFFF55};
    barramento.pedidoEntrada = 1'b0;
    barramento.entradaSwitch = 9'h000;
    modeloReset();
    @(negedge clock);
    comparaTudo();
    repeat (2) passo(1'b1, 9'h000, 1'b0);
    reset = 1'b1;
    // held button across a mid-wait reset must debounce again before capture
    repeat (3) passo(1'b1, 9'h033, 1'b1);
    repeat (2) passo(1'b0, 9'h033, 1'b1);
    aplicaReset();
    confere("reset_aguardando", 32'(barramento.aguardando), 32'd0);
    confere("reset_contagem", 32'(barramento.contagemEntradas), 32'd0);
    repeat (2) passo(1'b0, 9'h033, 1'b1);
    reset = 1'b1;
    n = 0; s0 = strobes;
    while (n < 30 && strobes == s0) begin passo(1'b0, 9'h033, 1'b1); n++; end
    confere("latencia_apos_reset", 32'(n), 32'(2 + D + 1));
    confere("dado_apos_reset", barramento.dado, 32'h00000033);
    passo(1'b0, 9'h033, 1'b0);
    // table of clean captures with expected sign extension
    foreach (tabela[k]) begin
      contSalva = barramento.contagemEntradas;
      captura(tabela[k].sw, novos);
      confere("strobes_por_captura", 32'(novos), 32'd1);
      confere("dado_tabela", barramento.dado, tabela[k].dadoEsperado);
      confere("contagem_incremento", 32'(barramento.contagemEntradas), 32'(contSalva + 8'd1));
    end
    // bounce shorter than the filter window is ignored, then one capture
    repeat (7) passo(1'b1, 9'h077, 1'b0);
    s0 = strobes;
    for (int i = 0; i < 20; i++) passo(((i / 2) % 2 == 0) ? 1'b0 : 1'b1, 9'h077, 1'b1);
    confere("strobes_durante_bounce", 32'(strobes - s0), 32'd0);
    for (int i = 0; i < 20; i++) passo(1'b0, 9'h077, 1'b1);
    confere("strobes_apos_bounce", 32'(strobes - s0), 32'd1);
    confere("dado_bounce", barramento.dado, 32'h00000077);
    passo(1'b1, 9'h077, 1'b0);
    // two requests with the button held: the second waits for release and a new press
    repeat (7) passo(1'b1, 9'h012, 1'b0);
    s0 = strobes; contSalva = barramento.contagemEntradas;
    for (int i = 0; i < 30 && strobes == s0; i++) passo(1'b0, 9'h012, 1'b1);
    repeat (10) passo(1'b0, 9'h034, 1'b1);
    confere("segundo_pedido_aguarda", 32'(barramento.aguardando), 32'd1);
    confere("sem_captura_duplicada", 32'(strobes - s0), 32'd1);
    repeat (8) passo(1'b1, 9'h034, 1'b1);
    for (int i = 0; i < 30 && strobes == s0 + 1; i++) passo(1'b0, 9'h034, 1'b1);
    confere("segunda_captura", barramento.dado, 32'h00000034);
    confere("contagem_dois_pedidos", 32'(barramento.contagemEntradas), 32'(contSalva + 8'd2));
    passo(1'b0, 9'h034, 1'b0);
    // abort while waiting for a press
    repeat (7) passo(1'b1, 9'h0AB, 1'b0);
    dadoSalvo = barramento.dado; contSalva = barramento.contagemEntradas; s0 = strobes;
    repeat (3) passo(1'b1, 9'h0AB, 1'b1);
    passo(1'b1, 9'h0AB, 1'b0);
    repeat (10) passo(1'b0, 9'h0AB, 1'b0);
    confere("abort_sem_strobe", 32'(strobes - s0), 32'd0);
    confere("abort_dado", barramento.dado, dadoSalvo);
    confere("abort_contagem", 32'(barramento.contagemEntradas), 32'(contSalva));
    // 256 captures wrap the counter back to zero
    aplicaReset();
    passo(1'b1, 9'h000, 1'b0);
    reset = 1'b1;
    s0 = strobes;
    for (int k = 0; k < 256; k++) captura(9'(k), novos);
    confere("strobes_256", 32'(strobes - s0), 32'd256);
    confere("contagem_volta_zero", 32'(barramento.contagemEntradas), 32'd0);
    // random button, request and switch activity with occasional resets
    for (int k = 0; k < 400; k++) begin
      len = $urandom_range(1, 8);
      e = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 80) == 0) begin
        aplicaReset();
        passo(e, 9'($urandom), p);
        reset = 1'b1;
      end
      repeat (len) passo(e, 9'($urandom), p);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
    $finish;
  end
endmodule
